// File: rtl/deinterleaver_pkg.sv
// Shared receiver definitions: rate encoding, per-rate symbol geometry and FSM state types
// used by the 802.11a deinterleaver.
package deinterleaver_pkg;

  localparam int MAX_CBPS = 288;
  localparam int ADDR_W   = 9;

  localparam logic [1:0] RATE_BPSK  = 2'b00;
  localparam logic [1:0] RATE_QPSK  = 2'b01;
  localparam logic [1:0] RATE_16QAM = 2'b10;
  localparam logic [1:0] RATE_64QAM = 2'b11;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;
  typedef enum logic {WR_FILL, WR_WAIT} wr_state_t;

  function automatic logic [ADDR_W-1:0] n_cbps_lookup(input logic [1:0] rate);
    logic [ADDR_W-1:0] n;
    case (rate)
      RATE_BPSK:  n = 9'd48;
      RATE_QPSK:  n = 9'd96;
      RATE_16QAM: n = 9'd192;
      default:    n = 9'd288;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] s_lookup(input logic [1:0] rate);
    logic [1:0] s;
    case (rate)
      RATE_BPSK:  s = 2'd1;
      RATE_QPSK:  s = 2'd1;
      RATE_16QAM: s = 2'd2;
      default:    s = 2'd3;
    endcase
    return s;
  endfunction

  // Rows per column of the 16-column interleaver matrix, i.e. N_CBPS/16.
  function automatic logic [4:0] rows_lookup(input logic [1:0] rate);
    logic [4:0] r;
    case (rate)
      RATE_BPSK:  r = 5'd3;
      RATE_QPSK:  r = 5'd6;
      RATE_16QAM: r = 5'd12;
      default:    r = 5'd18;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/deinterleaver_if.sv
// Bit-serial handshake bundle between demapper, deinterleaver and Viterbi decoder.
interface deinterleaver_if;

  logic       Input;
  logic       InputValid;
  logic       InputReady;
  logic [1:0] Rate;
  logic       Output;
  logic       OutputValid;
  logic       SymbolDone;

  modport master (
    output Input, InputValid, Rate,
    input  InputReady, Output, OutputValid, SymbolDone
  );

  modport slave (
    input  Input, InputValid, Rate,
    output InputReady, Output, OutputValid, SymbolDone
  );

endinterface

// File: rtl/deinterleaver_addr_gen.sv
// Incremental j -> k address generator: walks the 16-column matrix with row/column counters
// and rotates bits inside each s-bit group, so no divider is needed.
module deinterleaver_addr_gen
  import deinterleaver_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        rate,
  input  logic              start,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic       first;
  logic [1:0] s_q;
  logic [4:0] rows_q;
  logic [4:0] grp_row;
  logic [1:0] pos;
  logic [1:0] rot;
  logic [3:0] col;
  logic [1:0] s_eff;
  logic [4:0] rows_eff;
  logic [2:0] sum;
  logic [1:0] q;

  // Geometry comes from the live rate only while j=0; afterwards the latched copy is used.
  always_comb begin
    s_eff    = first ? s_lookup(rate)    : s_q;
    rows_eff = first ? rows_lookup(rate) : rows_q;
    sum      = {1'b0, pos} + {1'b0, rot};
    q        = (sum >= {1'b0, s_eff}) ? 2'(sum - {1'b0, s_eff}) : sum[1:0];
    addr     = {grp_row + 5'(q), col};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      first   <= 1'b1;
      s_q     <= 2'd1;
      rows_q  <= 5'd3;
      grp_row <= '0;
      pos     <= '0;
      rot     <= '0;
      col     <= '0;
    end else if (start) begin
      first   <= 1'b1;
      grp_row <= '0;
      pos     <= '0;
      rot     <= '0;
      col     <= '0;
    end else if (advance) begin
      first <= 1'b0;
      if (first) begin
        s_q    <= s_eff;
        rows_q <= rows_eff;
      end
      if (pos == s_eff - 2'd1) begin
        pos <= '0;
        // Group groups never straddle a column, so the rotation only steps on column change.
        if (grp_row + 5'(s_eff) == rows_eff) begin
          grp_row <= '0;
          col     <= col + 4'd1;
          rot     <= (rot == s_eff - 2'd1) ? 2'd0 : rot + 2'd1;
        end else begin
          grp_row <= grp_row + 5'(s_eff);
        end
      end else begin
        pos <= pos + 2'd1;
      end
    end
  end

endmodule

// File: rtl/deinterleaver.sv
// 802.11a receive deinterleaver: ping-pong symbol banks written in received order j and
// drained in coded order k at one bit per clock.
module deinterleaver #(
  parameter int MAX_CBPS = deinterleaver_pkg::MAX_CBPS,
  parameter int ADDR_W   = deinterleaver_pkg::ADDR_W
) (
  input logic           Clock,
  input logic           Reset,
  deinterleaver_if.slave bus
);

  import deinterleaver_pkg::*;

  logic [MAX_CBPS-1:0] bank_mem [2];
  logic [1:0]          bank_full;
  logic [ADDR_W-1:0]   bank_n [2];

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_j;
  logic [ADDR_W-1:0] wr_n;
  logic [ADDR_W-1:0] n_eff;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_k;
  logic              accept;
  logic              wr_last;
  logic              rd_emit;
  logic              rd_last;
  logic              out_bit;
  logic              out_valid;
  logic              sym_done;

  deinterleaver_addr_gen u_addr_gen (
    .Clock   (Clock),
    .Reset   (Reset),
    .rate    (bus.Rate),
    .start   (wr_last),
    .advance (accept),
    .addr    (wr_addr)
  );

  // Handshake and end-of-symbol detection; symbol length is taken from Rate only at j=0.
  always_comb begin
    accept  = bus.InputValid && (wr_state == WR_FILL);
    n_eff   = (wr_j == '0) ? ADDR_W'(n_cbps_lookup(bus.Rate)) : wr_n;
    wr_last = accept && (wr_j == n_eff - 1'b1);
    rd_emit = (rd_state == RD_READ) || ((rd_state == RD_IDLE) && bank_full[rd_bank]);
    rd_last = rd_emit && (rd_k == bank_n[rd_bank] - 1'b1);
  end

  // A bank released on this edge counts as free for the writer.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_FILL: if (wr_last && bank_full[~wr_bank] && !(rd_last && (rd_bank != wr_bank)))
                 wr_next = WR_WAIT;
      WR_WAIT: if (!bank_full[wr_bank] || (rd_last && (rd_bank == wr_bank)))
                 wr_next = WR_FILL;
      default: wr_next = WR_FILL;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (bank_full[rd_bank]) rd_next = RD_READ;
      RD_READ: if (rd_last) rd_next = bank_full[~rd_bank] ? RD_READ : RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_state <= WR_FILL;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_j      <= '0;
      wr_n      <= '0;
      rd_k      <= '0;
      bank_full <= '0;
      bank_n[0] <= '0;
      bank_n[1] <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      sym_done  <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_j == '0) wr_n <= n_eff;
        if (wr_last) begin
          wr_j            <= '0;
          wr_bank         <= ~wr_bank;
          bank_n[wr_bank] <= n_eff;
        end else begin
          wr_j <= wr_j + 1'b1;
        end
      end
      if (wr_last) bank_full[wr_bank] <= 1'b1;
      if (rd_last) bank_full[rd_bank] <= 1'b0;

      out_bit   <= rd_emit ? bank_mem[rd_bank][rd_k] : 1'b0;
      out_valid <= rd_emit;
      sym_done  <= rd_last;
      if (rd_emit) begin
        if (rd_last) begin
          rd_k    <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_k <= rd_k + 1'b1;
        end
      end
    end
  end

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (accept) bank_mem[wr_bank][wr_addr] <= bus.Input;
  end

  assign bus.InputReady  = (wr_state == WR_FILL);
  assign bus.Output      = out_bit;
  assign bus.OutputValid = out_valid;
  assign bus.SymbolDone  = sym_done;

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for the deinterleaver: one-hot symbols, mixed-rate streams against a
// formula-based reference interleaver, bank stalls and reset mid-symbol.
module tb_deinterleaver;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  deinterleaver_if bus();

  deinterleaver #(.MAX_CBPS(288), .ADDR_W(9)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  logic out_bits[$];
  int   out_cycle[$];
  int   done_cycle[$];

  always @(posedge Clock) cycle <= cycle + 1;

  always @(negedge Clock) begin
    if (bus.OutputValid === 1'b1) begin
      out_bits.push_back(bus.Output);
      out_cycle.push_back(cycle);
    end
    if (bus.SymbolDone === 1'b1) done_cycle.push_back(cycle);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int n_of(input logic [1:0] r);
    case (r)
      2'b00:   return 48;
      2'b01:   return 96;
      2'b10:   return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int s_of(input logic [1:0] r);
    case (r)
      2'b10:   return 2;
      2'b11:   return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int deint_k(input int n, input int s, input int j);
    int i;
    i = s * (j / s) + (j + (16 * j) / n) % s;
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  task automatic clear_mon();
    out_bits.delete();
    out_cycle.delete();
    done_cycle.delete();
  endtask

  task automatic send_symbol(input logic [1:0] r, input logic [287:0] bits, input int n,
                             input bit wobble, output int stalls, output int last_cycle);
    int   idx;
    int   guard;
    logic rdy;
    idx = 0; guard = 0; stalls = 0; last_cycle = -1;
    while (idx < n && guard < 4000) begin
      bus.Input      = bits[idx];
      bus.InputValid = 1'b1;
      bus.Rate       = (wobble && idx > 0) ? 2'($urandom_range(0, 3)) : r;
      @(negedge Clock);
      rdy = bus.InputReady;
      @(posedge Clock); #1;
      if (rdy === 1'b1) begin
        idx++;
        last_cycle = cycle;
      end else begin
        stalls++;
      end
      guard++;
    end
    bus.InputValid = 1'b0;
    compared++;
    if (idx != n) begin
      mismatched++;
      $display("[TB] FAIL send_symbol: accepted %0d bits, required %0d", idx, n);
    end
  endtask

  task automatic wait_outputs(input int count, input int budget);
    int g;
    g = 0;
    while (out_bits.size() < count && g < budget) begin
      @(posedge Clock); #1;
      g++;
    end
    repeat (4) begin
      @(posedge Clock); #1;
    end
  endtask

  function automatic logic [287:0] random_coded(input int n);
    logic [287:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [287:0] interleave(input logic [1:0] r, input logic [287:0] coded);
    logic [287:0] v;
    int n;
    int s;
    v = '0;
    n = n_of(r);
    s = s_of(r);
    for (int j = 0; j < n; j++) v[j] = coded[deint_k(n, s, j)];
    return v;
  endfunction

  function automatic logic [287:0] grab(input int base, input int n);
    logic [287:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      if (base + k < out_bits.size()) v[k] = out_bits[base + k];
    return v;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    bus.Input = 1'b0; bus.InputValid = 1'b0; bus.Rate = 2'b00;
    repeat (3) @(posedge Clock);
    #1;
    compared++; if (bus.Output !== 1'b0) begin mismatched++;
      $display("[TB] FAIL reset_output: got %b want 0", bus.Output); end
    compared++; if (bus.OutputValid !== 1'b0) begin mismatched++;
      $display("[TB] FAIL reset_valid: got %b want 0", bus.OutputValid); end
    compared++; if (bus.SymbolDone !== 1'b0) begin mismatched++;
      $display("[TB] FAIL reset_done: got %b want 0", bus.SymbolDone); end
    compared++; if (bus.InputReady !== 1'b1) begin mismatched++;
      $display("[TB] FAIL reset_ready: got %b want 1", bus.InputReady); end
    Reset = 1'b0;
    repeat (2) begin @(posedge Clock); #1; end
    compared++; if (bus.OutputValid !== 1'b0) begin mismatched++;
      $display("[TB] FAIL post_reset_valid: got %b want 0", bus.OutputValid); end
    compared++; if (bus.InputReady !== 1'b1) begin mismatched++;
      $display("[TB] FAIL post_reset_ready: got %b want 1", bus.InputReady); end
  endtask

  task automatic test_one_hot(input logic [1:0] r, input int jpos, input int kexp);
    logic [287:0] bits;
    logic [287:0] expv;
    logic [287:0] got;
    int n, stalls, last, first;
    n = n_of(r);
    bits = '0; bits[jpos] = 1'b1;
    expv = '0; expv[kexp] = 1'b1;
    clear_mon();
    send_symbol(r, bits, n, 1'b0, stalls, last);
    wait_outputs(n, n + 20);
    got = grab(0, n);
    first = (out_cycle.size() > 0) ? out_cycle[0] : -1;
    compared++; if (out_bits.size() != n) begin mismatched++;
      $display("[TB] FAIL one_hot_count rate=%0d: got %0d want %0d", r, out_bits.size(), n); end
    compared++; if (got !== expv) begin mismatched++;
      $display("[TB] FAIL one_hot_data rate=%0d j=%0d: got %h want %h", r, jpos, got, expv); end
    compared++; if (first != last + 1) begin mismatched++;
      $display("[TB] FAIL one_hot_latency rate=%0d: got cycle %0d want %0d", r, first, last + 1); end
    compared++; if (done_cycle.size() != 1) begin mismatched++;
      $display("[TB] FAIL one_hot_done_count rate=%0d: got %0d want 1", r, done_cycle.size()); end
    else begin
      compared++; if (done_cycle[0] != last + n) begin mismatched++;
        $display("[TB] FAIL one_hot_done_cycle rate=%0d: got %0d want %0d", r, done_cycle[0], last + n); end
    end
  endtask

  task automatic test_random_stream();
    logic [287:0] coded [20];
    logic [1:0]   rates [20];
    int n, stalls, last, total, base;
    clear_mon();
    total = 0;
    for (int sy = 0; sy < 20; sy++) begin
      rates[sy] = 2'($urandom_range(0, 3));
      n = n_of(rates[sy]);
      coded[sy] = random_coded(n);
      send_symbol(rates[sy], interleave(rates[sy], coded[sy]), n, 1'b1, stalls, last);
      total += n;
    end
    wait_outputs(total, total + 3000);
    compared++; if (out_bits.size() != total) begin mismatched++;
      $display("[TB] FAIL stream_count: got %0d want %0d", out_bits.size(), total); end
    base = 0;
    for (int sy = 0; sy < 20; sy++) begin
      n = n_of(rates[sy]);
      compared++; if (grab(base, n) !== coded[sy]) begin mismatched++;
        $display("[TB] FAIL stream_symbol %0d rate=%0d: got %h want %h", sy, rates[sy], grab(base, n), coded[sy]); end
      base += n;
    end
    compared++; if (done_cycle.size() != 20) begin mismatched++;
      $display("[TB] FAIL stream_done_count: got %0d want 20", done_cycle.size()); end
  endtask

  task automatic test_rate_switch();
    logic [287:0] c0, c1, c2;
    int st0, st1, st2, last, span;
    clear_mon();
    c0 = random_coded(288);
    c1 = random_coded(48);
    c2 = random_coded(48);
    send_symbol(2'b11, interleave(2'b11, c0), 288, 1'b0, st0, last);
    send_symbol(2'b00, interleave(2'b00, c1), 48, 1'b0, st1, last);
    send_symbol(2'b00, interleave(2'b00, c2), 48, 1'b0, st2, last);
    wait_outputs(384, 600);
    span = (out_cycle.size() > 0) ? out_cycle[out_cycle.size() - 1] - out_cycle[0] : -1;
    compared++; if (st0 != 0 || st1 != 0) begin mismatched++;
      $display("[TB] FAIL switch_early_stalls: got %0d/%0d want 0/0", st0, st1); end
    compared++; if (st2 != 240) begin mismatched++;
      $display("[TB] FAIL switch_wait_stalls: got %0d want 240", st2); end
    compared++; if (out_bits.size() != 384) begin mismatched++;
      $display("[TB] FAIL switch_count: got %0d want 384", out_bits.size()); end
    compared++; if (span != 383) begin mismatched++;
      $display("[TB] FAIL switch_contiguous: got span %0d want 383", span); end
    compared++; if (grab(0, 288) !== c0) begin mismatched++;
      $display("[TB] FAIL switch_qam64_data: got %h want %h", grab(0, 288), c0); end
    compared++; if (grab(288, 48) !== c1) begin mismatched++;
      $display("[TB] FAIL switch_bpsk1_data: got %h want %h", grab(288, 48), c1); end
    compared++; if (grab(336, 48) !== c2) begin mismatched++;
      $display("[TB] FAIL switch_bpsk2_data: got %h want %h", grab(336, 48), c2); end
  endtask

  task automatic test_back_to_back();
    logic [287:0] c0, c1;
    int st0, st1, last, span;
    clear_mon();
    c0 = random_coded(48);
    c1 = random_coded(48);
    send_symbol(2'b00, interleave(2'b00, c0), 48, 1'b0, st0, last);
    send_symbol(2'b00, interleave(2'b00, c1), 48, 1'b0, st1, last);
    wait_outputs(96, 200);
    span = (out_cycle.size() > 0) ? out_cycle[out_cycle.size() - 1] - out_cycle[0] : -1;
    compared++; if (st0 + st1 != 0) begin mismatched++;
      $display("[TB] FAIL b2b_ready: got %0d stall cycles want 0", st0 + st1); end
    compared++; if (out_bits.size() != 96) begin mismatched++;
      $display("[TB] FAIL b2b_count: got %0d want 96", out_bits.size()); end
    compared++; if (span != 95) begin mismatched++;
      $display("[TB] FAIL b2b_contiguous: got span %0d want 95", span); end
    compared++; if ({grab(48, 48), grab(0, 48)} !== {c1, c0}) begin mismatched++;
      $display("[TB] FAIL b2b_data: got %h/%h want %h/%h", grab(0, 48), grab(48, 48), c0, c1); end
    compared++; if (done_cycle.size() != 2) begin mismatched++;
      $display("[TB] FAIL b2b_done_count: got %0d want 2", done_cycle.size()); end
  endtask

  task automatic test_reset_mid_symbol();
    logic [287:0] c0, c1, c2;
    int st, last;
    clear_mon();
    c0 = random_coded(288);
    c1 = random_coded(288);
    c2 = random_coded(48);
    send_symbol(2'b11, interleave(2'b11, c0), 288, 1'b0, st, last);
    send_symbol(2'b11, interleave(2'b11, c1), 100, 1'b0, st, last);
    compared++; if (bus.OutputValid !== 1'b1) begin mismatched++;
      $display("[TB] FAIL midrst_draining: got %b want 1", bus.OutputValid); end
    Reset = 1'b1;
    #1;
    compared++; if (bus.OutputValid !== 1'b0 || bus.Output !== 1'b0 || bus.SymbolDone !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: got v=%b o=%b d=%b want 0/0/0", bus.OutputValid, bus.Output, bus.SymbolDone); end
    compared++; if (bus.InputReady !== 1'b1) begin mismatched++;
      $display("[TB] FAIL midrst_ready: got %b want 1", bus.InputReady); end
    @(posedge Clock); #1;
    Reset = 1'b0;
    clear_mon();
    repeat (300) begin @(posedge Clock); #1; end
    compared++; if (out_bits.size() != 0) begin mismatched++;
      $display("[TB] FAIL midrst_no_output: got %0d bits want 0", out_bits.size()); end
    send_symbol(2'b00, interleave(2'b00, c2), 48, 1'b0, st, last);
    wait_outputs(48, 80);
    compared++; if (out_bits.size() != 48) begin mismatched++;
      $display("[TB] FAIL midrst_after_count: got %0d want 48", out_bits.size()); end
    compared++; if (grab(0, 48) !== c2) begin mismatched++;
      $display("[TB] FAIL midrst_after_data: got %h want %h", grab(0, 48), c2); end
  endtask

  initial begin
    test_reset();
    test_one_hot(2'b00, 1, 16);
    test_one_hot(2'b01, 6, 1);
    test_one_hot(2'b10, 12, 17);
    test_one_hot(2'b11, 18, 17);
    test_one_hot(2'b10, 13, 1);
    test_one_hot(2'b00, 47, 47);
    test_one_hot(2'b11, 287, 287);
    test_random_stream();
    test_rate_switch();
    test_back_to_back();
    test_reset_mid_symbol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/deinterleaver.md
# deinterleaver

- Receive-path block sitting directly upstream of the Viterbi decoder, downstream of the demapper.
- Takes one OFDM symbol of hard-decision coded bits, serially in received order j, and undoes the 802.11a two-step interleaver.
- Emits the same bits serially in coded order k.
- Uses a ping-pong pair of symbol banks, so one symbol is written while the previous one is read out at one bit per clock.

## Interface
Parameters:
- MAX_CBPS, 288, bank depth in bits (64-QAM symbol).
- ADDR_W, 9, bank address width.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high.
- Input  in  1  coded bit j of the current symbol.
- InputValid  in  1  Input carries a bit this cycle.
- InputReady  out  1  block accepts a bit this cycle; a bit transfers when InputValid and InputReady are both high at a rising edge.
- Rate  in  2  modulation: 00 BPSK (N_CBPS=48, s=1), 01 QPSK (96, s=1), 10 16-QAM (192, s=2), 11 64-QAM (288, s=3).
- Output  out  1  deinterleaved bit k.
- OutputValid  out  1  Output is meaningful this cycle; there is no backpressure.
- SymbolDone  out  1  one-cycle pulse together with the last output bit of a symbol.

## Operation
- Rate is sampled on the accepted bit with j=0 and held for that symbol; Rate changes mid-symbol are ignored.
- Write side maps each accepted bit to a bank address:
  - i = s*floor(j/s) + (j + floor(16j/N_CBPS)) mod s
  - k = 16i − (N_CBPS−1)*floor(16i/N_CBPS)
  - The bit is stored at address k of the write bank.
- Address generation is counter-based, with no runtime dividers:
  - a row/column counter pair for the 16-column structure;
  - a mod-s rotator.
- After j = N_CBPS−1 is accepted:
  - the write bank is marked full together with its latched N_CBPS;
  - banks swap roles;
  - j clears.
- Read side drains the full bank in order k = 0 … N_CBPS−1, one bit per clock, then marks the bank empty.
- InputReady = 1 unless the bank that would be written next is full and not yet released. Example: a 288-bit symbol still draining while a following 48-bit symbol has already completed.
- Bits presented while InputReady = 0 are not accepted; the upstream block holds them.
- Read-side FSM states:
  - IDLE: no full bank → stays IDLE.
  - READ: drains the current bank. On its last bit, goes to READ on the other bank if that bank is already full, otherwise to IDLE.
- Write-side FSM states:
  - FILL: accepts bits.
  - WAIT: next bank busy, InputReady = 0. Returns to FILL on the edge the bank is released.

## Timing
- Reset values:
  - Output=0, OutputValid=0, SymbolDone=0, InputReady=1.
  - Both banks empty, j=0, read FSM in IDLE, write FSM in FILL.
- Bank contents are not cleared.
- Latency: last bit of a symbol accepted at edge T → at edge T+1, Output = bit k=0 and OutputValid=1. Bit k appears after edge T+1+k.
- SymbolDone is high after edge T+N_CBPS.
- Back-to-back same-rate symbols at 1 bit/clock stream with no gap in OutputValid, and InputReady never drops.
- Simultaneous events:
  - A bank becoming full on the same edge the other bank's last bit is read: the read continues seamlessly into the new bank.
  - A bank released on the same edge it is needed for writing: counts as free, so InputReady stays 1.
- Reset mid-symbol: returns immediately to the reset state; partial symbols are discarded.
- Counter widths:
  - j and k fit ADDR_W;
  - 16i needs ADDR_W+4 bits.

## Structure
- Shared receiver package holds:
  - the Rate encoding constants;
  - an N_CBPS lookup (48/96/192/288);
  - an s lookup (1/1/2/3);
  - MAX_CBPS.
- One sub-module, deinterleaver_addr_gen: given Rate, a start signal and an advance signal, produces the write address k for the next j incrementally. Its verification is standalone: exhaustive comparison of k against the formula for all four rates.
- Top level holds the banks, both FSMs and the handshake.

## Test plan
- BPSK, single one-hot symbol with bit j=1 set → only output k=16 is 1. First OutputValid comes the cycle after the 48th accepted bit; SymbolDone on the 48th output.
- QPSK, one-hot at j=6 → output k=1 is 1. 16-QAM, one-hot at j=12 → output k=17 is 1. 64-QAM, one-hot at j=18 → output k=17 is 1.
- Random data through a reference interleaver, then this block, 20 symbols mixed rates at 1 bit/clock → outputs equal the original sequence bit-exact.
- 64-QAM symbol followed immediately by a BPSK symbol → InputReady drops after the BPSK symbol's 48th bit until the 288-bit drain completes, and no data is lost.
- Two consecutive BPSK symbols at full rate → 96 contiguous OutputValid cycles and InputReady constantly 1.
- Reset asserted at j=100 of a 64-QAM symbol → all outputs take reset values immediately, no OutputValid follows, and a subsequent BPSK symbol decodes correctly.
